instr_issue_scheduler: RTL and testbench

- Buffers 8-bit host instructions in a FIFO and issues them one at a time to the main control FSM.
- Sits between the host interface and the FSM's host_instruction input.
- Presents each instruction for exactly one cycle, then drives NOP (8'h00).
- Tracks the FSM busy handshake so that a new instruction is never issued while the previous one is in flight.

---
 rtl/instr_issue_scheduler.sv | 131 +++++++++++++
 tb/tb_instr_issue_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_scheduler.sv
// Instruction issue scheduler: FIFO-buffers host instructions and issues them one at a time to the control FSM.
// Optional build macro INSTR_COUNT_EN adds a saturating retired-instruction counter.
module instr_issue_scheduler #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   host_instruction,
  input  logic                         host_valid,
  output logic                         host_ready,
  output logic [7:0]                   fsm_instruction,
  input  logic                         fsm_busy,
  output logic                         idle,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [15:0]                  retired_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 2);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      instr_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [LW-1:0]   level_d;

  logic push_c;
  logic pop_c;
  logic retire_c;

  // NOPs complete the handshake but never occupy a slot
  assign push_c   = host_valid && host_ready && (host_instruction != 8'h00);
  assign pop_c    = (state_q == S_IDLE) && (level_q != '0);
  assign retire_c = ((state_q == S_WAIT_BUSY) && !fsm_busy && (cnt_q == CW'(ACK_TIMEOUT))) ||
                    ((state_q == S_WAIT_DONE) && !fsm_busy);
  assign level_d  = level_q + LW'(push_c) - LW'(pop_c);

  assign host_ready      = (level_q != LW'(DEPTH));
  assign idle            = (state_q == S_IDLE) && (level_q == '0);
  assign level           = level_q;
  assign fsm_instruction = instr_q;

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= host_instruction;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  // Issue FSM: one-cycle instruction pulse, then track the busy handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      instr_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          instr_q <= 8'h00;
          if (pop_c) begin
            instr_q <= mem_q[rd_ptr_q];
            cnt_q   <= '0;
            state_q <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          instr_q <= 8'h00;
          cnt_q   <= cnt_q + CW'(1);
          if (fsm_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (retire_c) begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT_DONE: begin
          instr_q <= 8'h00;
          if (retire_c) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          instr_q <= 8'h00;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= 16'h0000;
    end else if (retire_c && (retired_q != 16'hFFFF)) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign retired_count = retired_q;
`else
  assign retired_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_issue_scheduler.sv
// Self-checking bench for instr_issue_scheduler: scoreboard of expected issues plus a model FSM busy responder.
module tb_instr_issue_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  host_instruction = 8'h00;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [7:0]  fsm_instruction;
  logic        fsm_busy;
  logic        idle;
  logic [3:0]  level;
  logic [15:0] retired_count;

`ifdef INSTR_COUNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int issue_total = 0;
  int max_level = 0;
  int busy_len = 0;
  int rem = 0;
  logic model_busy = 1'b0;
  logic busy_force = 1'b0;
  logic [7:0] prev_instr = 8'h00;
  logic [7:0] exp_q[$];
  int issue_cyc_q[$];

  assign fsm_busy = model_busy | busy_force;

  instr_issue_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .host_instruction (host_instruction),
    .host_valid       (host_valid),
    .host_ready       (host_ready),
    .fsm_instruction  (fsm_instruction),
    .fsm_busy         (fsm_busy),
    .idle             (idle),
    .level            (level),
    .retired_count    (retired_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model FSM: raises busy in the issue cycle and holds it for busy_len cycles
  always @(negedge clk) begin
    if (reset) begin
      model_busy = 1'b0;
      rem = 0;
    end else if (fsm_instruction != 8'h00 && busy_len > 0) begin
      model_busy = 1'b1;
      rem = busy_len;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) model_busy = 1'b0;
    end
  end

  // Scoreboard monitor: every issued instruction must match the head of exp_q
  always @(negedge clk) begin
    logic [7:0] e;
    if (int'(level) > max_level) max_level = int'(level);
    if (fsm_instruction !== 8'h00) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL issue_unexpected: got %h, expected no issue (cycle %0d)", fsm_instruction, cyc);
      end else begin
        e = exp_q.pop_front();
        if (fsm_instruction !== e) begin
          tests_failed++;
          $display("FAIL issue_order: got %h, expected %h (cycle %0d)", fsm_instruction, e, cyc);
        end
      end
      tests_run++;
      if (prev_instr !== 8'h00) begin
        tests_failed++;
        $display("FAIL issue_pulse_width: got %h in consecutive cycles, expected one-cycle pulse", fsm_instruction);
      end
      issue_cyc_q.push_back(cyc);
      issue_total++;
    end
    prev_instr = fsm_instruction;
  end

  task automatic push(input logic [7:0] v, output int p);
    int w;
    w = 0;
    @(negedge clk);
    host_valid = 1'b1;
    host_instruction = v;
    while (host_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    tests_run++;
    if (host_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL push_accept: host_ready=%b, expected 1 within 200 cycles", host_ready);
    end else if (v != 8'h00) begin
      exp_q.push_back(v);
    end
    p = cyc + 1;
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    host_instruction = 8'h00;
  endtask

  task automatic wait_idle(input int bound, output int t);
    int w;
    w = 0;
    t = -1;
    while (w < bound) begin
      @(negedge clk);
      w++;
      if (idle === 1'b1 && exp_q.size() == 0) begin
        t = cyc;
        break;
      end
    end
    tests_run++;
    if (t < 0) begin
      tests_failed++;
      $display("FAIL wait_idle: idle=%b queue=%0d, expected drained idle within %0d cycles", idle, exp_q.size(), bound);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    busy_force = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (fsm_instruction !== 8'h00 || host_ready !== 1'b1 || idle !== 1'b1 ||
        level !== 4'd0 || retired_count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_values: got instr=%h ready=%b idle=%b level=%0d retired=%0d, expected 00 1 1 0 0",
               fsm_instruction, host_ready, idle, level, retired_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_issue();
    int p, t;
    busy_len = 64;
    issue_cyc_q.delete();
    push(8'h04, p);
    wait_idle(200, t);
    tests_run++;
    if (issue_cyc_q.size() != 1 || issue_cyc_q[0] != p + 1) begin
      tests_failed++;
      $display("FAIL single_latency: issues=%0d first=%0d, expected 1 issue at cycle %0d",
               issue_cyc_q.size(), (issue_cyc_q.size() > 0) ? issue_cyc_q[0] : -1, p + 1);
    end
    tests_run++;
    if (t != p + 66) begin
      tests_failed++;
      $display("FAIL single_idle_return: got cycle %0d, expected %0d", t, p + 66);
    end
  endtask

  task automatic test_back_to_back();
    int p, t;
    busy_len = 10;
    max_level = 0;
    issue_cyc_q.delete();
    push(8'h45, p);
    push(8'h95, p);
    push(8'h35, p);
    wait_idle(200, t);
    tests_run++;
    if (max_level != 2) begin
      tests_failed++;
      $display("FAIL b2b_level_peak: got %0d, expected 2", max_level);
    end
    tests_run++;
    if (issue_cyc_q.size() != 3 || issue_cyc_q[1] - issue_cyc_q[0] < 12 || issue_cyc_q[2] - issue_cyc_q[1] < 12) begin
      tests_failed++;
      $display("FAIL b2b_spacing: issues=%0d, expected 3 issues spaced >= 12 cycles", issue_cyc_q.size());
    end
  endtask

  task automatic test_full();
    int p, t;
    busy_len = 0;
    busy_force = 1'b1;
    for (int i = 0; i < 9; i++) push(8'(8'h11 + i), p);
    @(negedge clk);
    tests_run++;
    if (level !== 4'd8 || host_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_level: got level=%0d ready=%b, expected 8 0", level, host_ready);
    end
    host_valid = 1'b1;
    host_instruction = 8'hAA;
    repeat (3) @(negedge clk);
    tests_run++;
    if (host_ready !== 1'b0 || level !== 4'd8) begin
      tests_failed++;
      $display("FAIL full_stall: got ready=%b level=%0d, expected 0 8", host_ready, level);
    end
    busy_force = 1'b0;
    @(negedge clk);
    tests_run++;
    if (host_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_ready_early: got %b, expected 0", host_ready);
    end
    @(negedge clk);
    tests_run++;
    if (host_ready !== 1'b1 || level !== 4'd7) begin
      tests_failed++;
      $display("FAIL full_ready_reassert: got ready=%b level=%0d, expected 1 7", host_ready, level);
    end
    exp_q.push_back(8'hAA);
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    host_instruction = 8'h00;
    wait_idle(300, t);
  endtask

  task automatic test_nop_filter();
    int p, t;
    busy_len = 3;
    issue_cyc_q.delete();
    push(8'h07, p);
    push(8'h00, p);
    @(negedge clk);
    tests_run++;
    if (level !== 4'd0) begin
      tests_failed++;
      $display("FAIL nop_level: got %0d, expected 0", level);
    end
    push(8'h47, p);
    wait_idle(100, t);
    tests_run++;
    if (issue_cyc_q.size() != 2) begin
      tests_failed++;
      $display("FAIL nop_issue_count: got %0d, expected 2", issue_cyc_q.size());
    end
  endtask

  task automatic test_timeout();
    int p, t;
    apply_reset();
    busy_len = 0;
    push(8'h1C, p);
    wait_idle(50, t);
    tests_run++;
    if (t != p + 6) begin
      tests_failed++;
      $display("FAIL timeout_return: got cycle %0d, expected %0d", t, p + 6);
    end
    tests_run++;
    if (retired_count !== 16'(CNT_EN)) begin
      tests_failed++;
      $display("FAIL timeout_retired: got %0d, expected %0d", retired_count, CNT_EN);
    end
  endtask

  task automatic test_reset_mid();
    int p, t, n;
    apply_reset();
    busy_len = 0;
    busy_force = 1'b1;
    push(8'h61, p);
    push(8'h62, p);
    push(8'h63, p);
    push(8'h64, p);
    @(negedge clk);
    tests_run++;
    if (level !== 4'd3) begin
      tests_failed++;
      $display("FAIL midreset_prelevel: got %0d, expected 3", level);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (fsm_instruction !== 8'h00 || host_ready !== 1'b1 || idle !== 1'b1 ||
        level !== 4'd0 || retired_count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midreset_values: got instr=%h ready=%b idle=%b level=%0d retired=%0d, expected 00 1 1 0 0",
               fsm_instruction, host_ready, idle, level, retired_count);
    end
    exp_q.delete();
    busy_force = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = issue_total;
    repeat (20) @(negedge clk);
    tests_run++;
    if (issue_total != n || idle !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_quiet: got %0d issues idle=%b, expected 0 issues idle=1", issue_total - n, idle);
    end
    push(8'h5A, p);
    wait_idle(50, t);
    tests_run++;
    if (retired_count !== 16'(CNT_EN)) begin
      tests_failed++;
      $display("FAIL midreset_retired: got %0d, expected %0d", retired_count, CNT_EN);
    end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_back_to_back();
    test_full();
    test_nop_filter();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
